// File: rtl/regfile_sb_if.sv
// Register file bus: read ports, writeback, issue and ready status.
//   rd_adr    NRD*AW    read addresses, port p at [p*AW +: AW]
//   rd_data   NRD*XLEN  combinational read data, port p at [p*XLEN +: XLEN]
//   rd_busy   NRD       port p's register has a pending writeback
//   en/wa/wd            writeback enable, address, data
//   issue_en/issue_adr  mark a destination register as having an in-flight producer
//   ready               clear sweep finished, block accepts traffic
// master = decode/writeback side, slave = register file.
interface regfile_sb_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned NRD  = 2
);
    localparam int unsigned AW = $clog2(NREG);

    logic [NRD*AW-1:0]   rd_adr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                en;
    logic [AW-1:0]       wa;
    logic [XLEN-1:0]     wd;
    logic                issue_en;
    logic [AW-1:0]       issue_adr;
    logic                ready;

    modport master (
        output rd_adr, en, wa, wd, issue_en, issue_adr,
        input  rd_data, rd_busy, ready
    );

    modport slave (
        input  rd_adr, en, wa, wd, issue_en, issue_adr,
        output rd_data, rd_busy, ready
    );
endinterface

// File: rtl/regfile_sb.sv
// Multi-read-port integer register file with write-to-read bypass and a
// per-register busy scoreboard. After reset a sequential sweep clears the
// array one register per cycle; ready rises once the sweep is done.
//   clk  clock, all state on the rising edge
//   rst  synchronous active-high reset
//   bus  regfile_sb_if.slave (reads, writeback, issue, ready)
module regfile_sb #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREG     = 32,
    parameter int unsigned NRD      = 2,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    regfile_sb_if.slave bus
);
    localparam int unsigned AW = $clog2(NREG);

    typedef enum logic {StClear, StRun} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic [XLEN-1:0] mem_q [NREG];

    logic            run;
    logic            wr_ok;
    logic            issue_ok;
    logic            mem_we;
    logic [AW-1:0]   mem_wa;
    logic [XLEN-1:0] mem_wdata;

    logic [AW-1:0]       rd_adr_a [NRD];
    logic [NRD-1:0]      hit;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;

    assign run = (state_q == StRun);

    // Writes to x0 are dropped, and such a write must not bypass either.
    assign wr_ok    = bus.en && !(ZERO_REG && (bus.wa == '0));
    assign issue_ok = bus.issue_en && !(ZERO_REG && (bus.issue_adr == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StClear;
            idx_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
        end
    end

    // Array has no reset; the sweep clears it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        mem_we    = 1'b0;
        mem_wa    = idx_q;
        mem_wdata = '0;
        unique case (state_q)
            StClear: begin
                mem_we = 1'b1;
                idx_d  = idx_q + 1'b1;
                if (idx_q == AW'(NREG - 1)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                mem_we    = wr_ok;
                mem_wa    = bus.wa;
                mem_wdata = bus.wd;
                // Issue is applied after writeback so it wins on the same address.
                if (bus.en) begin
                    busy_d[bus.wa] = 1'b0;
                end
                if (issue_ok) begin
                    busy_d[bus.issue_adr] = 1'b1;
                end
            end
            default: state_d = StClear;
        endcase
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        hit     = '0;
        for (int p = 0; p < NRD; p++) begin
            rd_adr_a[p] = bus.rd_adr[p*AW +: AW];
        end
        for (int p = 0; p < NRD; p++) begin
            hit[p] = BYPASS && wr_ok && (bus.wa == rd_adr_a[p]);
            if (run) begin
                if (ZERO_REG && (rd_adr_a[p] == '0)) begin
                    rd_data[p*XLEN +: XLEN] = '0;
                end else if (hit[p]) begin
                    rd_data[p*XLEN +: XLEN] = bus.wd;
                end else begin
                    rd_data[p*XLEN +: XLEN] = mem_q[rd_adr_a[p]];
                end
                rd_busy[p] = busy_q[rd_adr_a[p]] & ~hit[p];
            end
        end
    end

    assign bus.rd_data = rd_data;
    assign bus.rd_busy = rd_busy;
    assign bus.ready   = run;
endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned NRD  = 2;
    localparam int unsigned AW   = 5;

    typedef struct {
        string       name;
        int          kind;   // 0 data, 1 busy, 2 ready
        int          port;
        logic [31:0] exp;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    item_t sb_q[$];
    int checks = 0;
    int passed = 0;

    regfile_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus ();

    regfile_sb #(
        .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .ZERO_REG(1'b1), .BYPASS(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic push(input string nm, input int kind, input int port, input logic [31:0] v);
        item_t it;
        it.name = nm;
        it.kind = kind;
        it.port = port;
        it.exp  = v;
        sb_q.push_back(it);
    endtask

    task automatic set_rd(input int a0, input int a1);
        bus.rd_adr[0 +: AW]  = AW'(a0);
        bus.rd_adr[AW +: AW] = AW'(a1);
    endtask

    // Monitor: outputs are sampled 2 time units after each negedge, well away
    // from the rising edge; everything queued for this cycle is compared.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            while (sb_q.size() > 0) begin
                item_t it;
                logic [31:0] act;
                it = sb_q.pop_front();
                case (it.kind)
                    0:       act = bus.rd_data[it.port*XLEN +: XLEN];
                    1:       act = {31'd0, bus.rd_busy[it.port]};
                    default: act = {31'd0, bus.ready};
                endcase
                checks++;
                if (act === it.exp) begin
                    passed++;
                end else begin
                    $display("FAIL %s port%0d: got %h expected %h", it.name, it.port, act, it.exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.en = 1'b0;
        bus.wa = '0;
        bus.wd = '0;
        bus.issue_en = 1'b0;
        bus.issue_adr = '0;
        set_rd(0, 0);

        // 1: reset sweep
        @(negedge clk);
        rst = 1'b0;
        push("reset_ready", 2, 0, 0);
        push("reset_busy0", 1, 0, 0);
        push("reset_data0", 0, 0, 0);
        for (int j = 1; j <= 32; j++) begin
            @(negedge clk);
            push("sweep_ready", 2, 0, (j == 32) ? 32'd1 : 32'd0);
        end
        for (int r = 0; r < 32; r += 2) begin
            set_rd(r, r + 1);
            push("clear_data", 0, 0, 0);
            push("clear_data", 0, 1, 0);
            push("clear_busy", 1, 0, 0);
            push("clear_busy", 1, 1, 0);
            @(negedge clk);
        end

        // 2: bypass
        bus.en = 1'b1; bus.wa = 5'd5; bus.wd = 32'hDEADBEEF; set_rd(5, 6);
        push("bypass_data", 0, 0, 32'hDEADBEEF);
        push("bypass_busy", 1, 0, 0);
        push("bypass_other", 0, 1, 0);
        @(negedge clk);
        bus.en = 1'b0; set_rd(5, 5);
        push("held_data", 0, 0, 32'hDEADBEEF);
        push("held_data", 0, 1, 32'hDEADBEEF);
        @(negedge clk);

        // 3: x0 write dropped, x0 issue ignored
        bus.en = 1'b1; bus.wa = 5'd0; bus.wd = 32'h1234; set_rd(0, 5);
        push("x0_nobypass", 0, 0, 0);
        push("x0_other", 0, 1, 32'hDEADBEEF);
        @(negedge clk);
        bus.en = 1'b0; bus.issue_en = 1'b1; bus.issue_adr = 5'd0;
        push("x0_read", 0, 0, 0);
        @(negedge clk);
        bus.issue_en = 1'b0;
        push("x0_busy", 1, 0, 0);
        push("x0_read2", 0, 0, 0);
        @(negedge clk);

        // 4: issue then writeback
        bus.issue_en = 1'b1; bus.issue_adr = 5'd7; set_rd(7, 3);
        push("issue_same_cyc", 1, 0, 0);
        @(negedge clk);
        bus.issue_en = 1'b0; set_rd(7, 7);
        push("busy_set", 1, 0, 1);
        push("busy_set", 1, 1, 1);
        @(negedge clk);
        bus.en = 1'b1; bus.wa = 5'd7; bus.wd = 32'd9; set_rd(7, 3);
        push("wb_bypass_data", 0, 0, 9);
        push("wb_bypass_busy", 1, 0, 0);
        push("wb_other_data", 0, 1, 0);
        @(negedge clk);
        bus.en = 1'b0;
        push("wb_data", 0, 0, 9);
        push("wb_busy_clr", 1, 0, 0);
        @(negedge clk);

        // 5: issue and writeback to the same register
        bus.issue_en = 1'b1; bus.issue_adr = 5'd7;
        @(negedge clk);
        bus.en = 1'b1; bus.wa = 5'd7; bus.wd = 32'd3;
        push("race_bypass", 0, 0, 3);
        @(negedge clk);
        bus.en = 1'b0; bus.issue_en = 1'b0;
        push("race_data", 0, 0, 3);
        push("race_busy", 1, 0, 1);
        @(negedge clk);
        bus.en = 1'b1; bus.wd = 32'd3;
        @(negedge clk);
        bus.en = 1'b0;
        push("race_busy_clr", 1, 0, 0);

        // 6: reset mid-sweep with reg 20 holding a value
        bus.en = 1'b1; bus.wa = 5'd20; bus.wd = 32'h0000CAFE;
        @(negedge clk);
        bus.en = 1'b0; set_rd(20, 4);
        push("r20_pre", 0, 0, 32'h0000CAFE);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        push("rst_ready_drop", 2, 0, 0);
        push("clear_gated", 0, 0, 0);
        bus.issue_en = 1'b1; bus.issue_adr = 5'd4;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            push("mid_ready", 2, 0, 0);
            push("mid_gated", 0, 0, 0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.issue_en = 1'b0;
        push("rst2_ready", 2, 0, 0);
        for (int j = 1; j <= 32; j++) begin
            @(negedge clk);
            push("resweep_ready", 2, 0, (j == 32) ? 32'd1 : 32'd0);
        end
        push("r20_cleared", 0, 0, 0);
        push("r20_busy", 1, 0, 0);
        push("issue_in_clear", 1, 1, 0);
        @(negedge clk);
        #4;
        checks++;
        if (bus.ready === 1'b1) begin
            passed++;
        end else begin
            $display("FAIL final_ready: got %b expected 1", bus.ready);
        end
        checks++;
        if (bus.rd_data[0 +: XLEN] === 32'd0) begin
            passed++;
        end else begin
            $display("FAIL final_r20: got %h expected 0", bus.rd_data[0 +: XLEN]);
        end
        checks++;
        if (bus.rd_busy === 2'b00) begin
            passed++;
        end else begin
            $display("FAIL final_busy: got %b expected 00", bus.rd_busy);
        end
        $display("%0d/%0d checks passed", passed, checks);
        if (passed != checks) begin
            $display("FAIL summary: %0d checks failed", checks - passed);
        end else begin
            $display("PASS all checks");
        end
        $finish;
    end
endmodule
